// File: rtl/bus_send_arbiter.sv
// Funnels single-word offers from REQUESTERS sources onto the core receiver bus.
// Each source has a one-entry slot. A round-robin pointer picks which full slot to offer next.
module bus_send_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int REQUESTERS = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [REQUESTERS-1:0]                 req_valid,
    input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_data,
    output logic [REQUESTERS-1:0]                 req_ready,
    output logic                                  receiver_send,
    output logic [WORD_WIDTH-1:0]                 receiver_data,
    input  logic                                  receiver_send_ack,
    output logic [ID_WIDTH-1:0]                   grant_id,
    output logic [7:0]                            drop_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]                            state;
    logic [REQUESTERS-1:0]                 full;
    logic [REQUESTERS-1:0][WORD_WIDTH-1:0] slot_data;
    logic [ID_WIDTH-1:0]                   last_grant;
    logic [ID_WIDTH-1:0]                   sel_id;
    logic [ID_WIDTH-1:0]                   idx;
    logic                                  sel_any;
    logic                                  ack_hit;
    logic                                  any_drop;

    assign req_ready     = ~full;
    assign receiver_send = (state == OFFER);
    assign ack_hit       = (state == OFFER) && receiver_send_ack;
    assign any_drop      = |(req_valid & full);

    // Scan from farthest to nearest so the slot closest after last_grant wins.
    always_comb begin
        sel_any = 1'b0;
        sel_id  = '0;
        idx     = '0;
        for (int k = REQUESTERS; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(last_grant) + k) % REQUESTERS);
            if (full[idx]) begin
                sel_any = 1'b1;
                sel_id  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full      <= '0;
            slot_data <= '0;
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (ack_hit && int'(grant_id) == i) begin
                    full[i] <= 1'b0;
                end else if (req_valid[i] && !full[i]) begin
                    full[i]      <= 1'b1;
                    slot_data[i] <= req_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            receiver_data <= '0;
            grant_id      <= '0;
            last_grant    <= ID_WIDTH'(REQUESTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state         <= OFFER;
                        grant_id      <= sel_id;
                        receiver_data <= slot_data[sel_id];
                    end
                end
                default: begin
                    if (receiver_send_ack) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end
                end
            endcase
        end
    end

    // One count per edge on which any source offers into a full slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (any_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
